// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between execute, the load/store unit and writeback.
interface load_store_unit_if #(
  parameter int TAG_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [15:0]      req_base;
  logic [15:0]      req_offset;
  logic [15:0]      req_wdata;
  logic [TAG_W-1:0] req_rd;

  logic             resp_valid;
  logic             resp_ready;
  logic [15:0]      resp_rdata;
  logic [TAG_W-1:0] resp_rd;
  logic             resp_is_load;
  logic             resp_fault;

  modport master (
    output req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_is_load, resp_fault
  );

  modport slave (
    input  req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_is_load, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store stage: forms and range-checks the effective address,
// strobes the data memory for one cycle and returns a response to writeback.
module load_store_unit #(
  parameter int MEM_SIZE = 512,
  parameter int TAG_W    = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  load_store_unit_if.slave bus,
  output logic [CNT_W-1:0] fault_count,
  output logic             Mem_read,
  output logic             Mem_write,
  output logic [15:0]      Mem_add,
  output logic [15:0]      Mem_write_data,
  input  logic [15:0]      Mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_reg, state_next;
  logic             run_reg;
  logic [15:0]      ea_reg, wdata_reg, rdata_reg;
  logic [TAG_W-1:0] rd_reg;
  logic             load_reg, fault_reg;
  logic [CNT_W-1:0] fc_reg;

  logic [15:0] ea_next;
  logic        fault_next;
  logic        accept;

  // Address wraps modulo 2^16; the range check is done on the wrapped value.
  assign ea_next    = bus.req_base + bus.req_offset;
  assign fault_next = ({16'd0, ea_next} >= 32'(MEM_SIZE));
  assign accept     = (state_reg == IDLE) && run_reg && bus.req_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes decode from registered state only, so they fall with async reset.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    Mem_read       = 1'b0;
    Mem_write      = 1'b0;
    Mem_add        = 16'h0000;
    Mem_write_data = 16'h0000;
    case (state_reg)
      IDLE:   bus.req_ready = run_reg;
      ACCESS: begin
        if (!fault_reg) begin
          Mem_add        = ea_reg;
          Mem_write      = !load_reg;
          Mem_read       = load_reg;
          Mem_write_data = load_reg ? 16'h0000 : wdata_reg;
        end
      end
      RESP:   bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ea_reg    <= 16'h0000;
      wdata_reg <= 16'h0000;
      rdata_reg <= 16'h0000;
      rd_reg    <= '0;
      load_reg  <= 1'b0;
      fault_reg <= 1'b0;
      fc_reg    <= '0;
    end else begin
      if (accept) begin
        ea_reg    <= ea_next;
        wdata_reg <= bus.req_wdata;
        rd_reg    <= bus.req_rd;
        load_reg  <= !bus.req_is_store;
        fault_reg <= fault_next;
      end
      if (state_reg == ACCESS) begin
        rdata_reg <= (!fault_reg && load_reg) ? Mem_read_data : 16'h0000;
        if (fault_reg && (fc_reg != {CNT_W{1'b1}}))
          fc_reg <= fc_reg + CNT_W'(1);
      end
    end
  end

  assign bus.resp_rdata   = rdata_reg;
  assign bus.resp_rd      = rd_reg;
  assign bus.resp_is_load = load_reg;
  assign bus.resp_fault   = fault_reg;
  assign fault_count      = fc_reg;

endmodule
